// File: rtl/fifosc_param.sv
`default_nettype none
// ============================================================================
// Module   : fifosc_param
// Brief    : Parametrised single-clock synchronous FIFO with occupancy count,
//            programmable almost-full/almost-empty thresholds, overflow and
//            underflow pulses, and an optional first-word-fall-through mode.
// Revision : 1.0 - initial release
// ============================================================================
module fifosc_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  flush,
    input  logic                  insert,
    input  logic                  remove,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  c_depth    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_full_cnt = (ADDR_WIDTH+1)'(c_depth);
    localparam logic [ADDR_WIDTH:0] c_af_cnt   = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_ae_cnt   = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_cnt_one  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

    // Threshold configuration sanity checks, reported at elaboration.
    if (AF_LEVEL < 1 || AF_LEVEL > c_depth) begin : g_bad_af_level
        $error("fifosc_param: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, c_depth);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > c_depth - 1) begin : g_bad_ae_level
        $error("fifosc_param: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, c_depth - 1);
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fifosc_param: FWFT=%0d must be 0 or 1", FWFT);
    end

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [ADDR_WIDTH-1:0] r_wrptr;
    logic [ADDR_WIDTH-1:0] r_rdptr;

    logic                  w_bypass;
    logic                  w_do_insert;
    logic                  w_do_remove;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Accept decisions and next occupancy. In registered-read mode an
    // insert+remove on an empty FIFO passes di straight to dout and leaves
    // the storage untouched; a full FIFO accepts an insert only when the
    // same-cycle remove frees a slot.
    always_comb begin
        w_bypass    = (FWFT == 0) && empty && insert && remove;
        w_do_remove = remove && !empty;
        w_do_insert = insert && (!full || w_do_remove) && !w_bypass;
        w_count_nxt = count;
        if (w_do_insert && !w_do_remove) begin
            w_count_nxt = count + c_cnt_one;
        end else if (!w_do_insert && w_do_remove) begin
            w_count_nxt = count - c_cnt_one;
        end
    end

    // Pointers, occupancy, registered flags and error pulses.
    always_ff @(posedge clk) begin
        if (flush) begin
            r_wrptr      <= '0;
            r_rdptr      <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (w_do_insert) begin
                r_wrptr <= r_wrptr + c_ptr_one;
            end
            if (w_do_remove) begin
                r_rdptr <= r_rdptr + c_ptr_one;
            end
            count        <= w_count_nxt;
            empty        <= (w_count_nxt == '0);
            full         <= (w_count_nxt == c_full_cnt);
            almost_empty <= (w_count_nxt <= c_ae_cnt);
            almost_full  <= (w_count_nxt >= c_af_cnt);
            overflow     <= insert && !w_do_insert && !w_bypass;
            underflow    <= remove && !w_do_remove && !w_bypass;
        end
    end

    // Storage write; contents are deliberately not cleared by flush.
    always_ff @(posedge clk) begin
        if (!flush && w_do_insert) begin
            r_mem[r_wrptr] <= di;
        end
    end

    if (FWFT == 0) begin : g_registered_read
        // Registered read port: loads the head one cycle after a remove.
        always_ff @(posedge clk) begin
            if (flush) begin
                dout <= '0;
            end else if (w_bypass) begin
                dout <= di;
            end else if (w_do_remove) begin
                dout <= r_mem[r_rdptr];
            end
        end
    end else begin : g_fwft_read
        // Head word is always presented; forced to zero while empty so the
        // post-flush value is deterministic.
        assign dout = empty ? '0 : r_mem[r_rdptr];
    end

endmodule
`default_nettype wire

// File: tb/tb_fifosc_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifosc_param
// Brief    : Self-checking bench for fifosc_param (registered-read and FWFT).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifosc_param;

    logic       clk = 1'b0;
    logic       flush, insert, remove;
    logic [7:0] di, dout;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic [3:0] count;

    logic       f_flush, f_insert, f_remove;
    logic [7:0] f_di, f_dout;
    logic       f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
    logic [3:0] f_count;

    always #5 clk = ~clk;

    fifosc_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
        .clk(clk), .flush(flush), .insert(insert), .remove(remove), .di(di),
        .dout(dout), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifosc_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) dut_f (
        .clk(clk), .flush(f_flush), .insert(f_insert), .remove(f_remove), .di(f_di),
        .dout(f_dout), .empty(f_empty), .full(f_full), .almost_empty(f_almost_empty),
        .almost_full(f_almost_full), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    typedef struct packed {
        logic       fl;
        logic       ins;
        logic       rem;
        logic [7:0] di;
        logic [7:0] dout;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(int fl, int ins, int rem, int d, int exp_dout, int cnt, int ovf, int unf);
        vec_t v;
        v.fl   = fl[0];
        v.ins  = ins[0];
        v.rem  = rem[0];
        v.di   = 8'(d);
        v.dout = 8'(exp_dout);
        v.cnt  = 4'(cnt);
        v.ovf  = ovf[0];
        v.unf  = unf[0];
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock on the default-parameter DUT; outputs sampled 1 time unit after the edge.
    task automatic step(logic fl, logic ins, logic rem, logic [7:0] d);
        flush  = fl;
        insert = ins;
        remove = rem;
        di     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic fstep(logic fl, logic ins, logic rem, logic [7:0] d);
        f_flush  = fl;
        f_insert = ins;
        f_remove = rem;
        f_di     = d;
        @(posedge clk);
        #1;
    endtask

    vec_t       v;
    logic [7:0] exp_q[$];
    logic [7:0] exp_d;
    logic [7:0] wd;
    logic       wi, wr;
    int         mcnt;

    initial begin
        flush = 1'b0; insert = 1'b0; remove = 1'b0; di = 8'h00;
        f_flush = 1'b1; f_insert = 1'b0; f_remove = 1'b0; f_di = 8'h00;

        // ---------------- table: fill, overflow, drain, underflow, bypass, full swap
        add(1, 0, 0, 0, 8'h00, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 1, 0, k * 17, 8'h00, k, 0, 0);
        add(0, 1, 0, 8'h99, 8'h00, 8, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, k * 17, 8 - k, 0, 0);
        add(0, 0, 1, 0, 8'h88, 0, 0, 1);
        add(0, 1, 1, 8'h5A, 8'h5A, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 1, 0, 8'hA0 + k, 8'h5A, k, 0, 0);
        add(0, 1, 1, 8'hEE, 8'hA1, 8, 0, 0);
        for (int k = 2; k <= 8; k++) add(0, 0, 1, 0, 8'hA0 + k, 9 - k, 0, 0);
        add(0, 0, 1, 0, 8'hEE, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(v.fl, v.ins, v.rem, v.di);
            chk($sformatf("v%0d.dout", i), 32'(dout), 32'(v.dout));
            chk($sformatf("v%0d.count", i), 32'(count), 32'(v.cnt));
            chk($sformatf("v%0d.empty", i), 32'(empty), 32'(v.cnt == 4'd0));
            chk($sformatf("v%0d.full", i), 32'(full), 32'(v.cnt == 4'd8));
            chk($sformatf("v%0d.almost_empty", i), 32'(almost_empty), 32'(v.cnt <= 4'd1));
            chk($sformatf("v%0d.almost_full", i), 32'(almost_full), 32'(v.cnt >= 4'd6));
            chk($sformatf("v%0d.overflow", i), 32'(overflow), 32'(v.ovf));
            chk($sformatf("v%0d.underflow", i), 32'(underflow), 32'(v.unf));
        end

        // ---------------- wrap-around with a scoreboard, count kept within 2..5
        mcnt = 0;
        for (int i = 0; i < 3; i++) begin
            wd = 8'(8'hB0 + i);
            step(1'b0, 1'b1, 1'b0, wd);
            exp_q.push_back(wd);
            mcnt++;
        end
        chk("wrap.prefill_count", 32'(count), 32'(mcnt));
        for (int i = 0; i < 20; i++) begin
            wi = (i % 4 != 3) && (mcnt < 5);
            wr = (i % 4 != 0) && (mcnt > 2);
            wd = 8'(8'hC0 + i);
            step(1'b0, wi, wr, wd);
            if (wr) begin
                exp_d = exp_q.pop_front();
                chk($sformatf("wrap%0d.dout", i), 32'(dout), 32'(exp_d));
            end
            if (wi) exp_q.push_back(wd);
            mcnt = mcnt + int'(wi) - int'(wr);
            chk($sformatf("wrap%0d.count", i), 32'(count), 32'(mcnt));
        end
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            exp_d = exp_q.pop_front();
            chk($sformatf("drain%0d.dout", i), 32'(dout), 32'(exp_d));
        end
        chk("drain.empty", 32'(empty), 32'd1);

        // ---------------- flush mid-stream with insert+remove also high
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        chk("preflush.count", 32'(count), 32'd5);
        step(1'b1, 1'b1, 1'b1, 8'h77);
        chk("flush.count", 32'(count), 32'd0);
        chk("flush.empty", 32'(empty), 32'd1);
        chk("flush.dout", 32'(dout), 32'd0);
        chk("flush.almost_empty", 32'(almost_empty), 32'd1);
        chk("flush.almost_full", 32'(almost_full), 32'd0);
        chk("flush.overflow", 32'(overflow), 32'd0);
        chk("flush.underflow", 32'(underflow), 32'd0);
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        chk("postflush.count", 32'(count), 32'd3);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk($sformatf("postflush%0d.dout", i), 32'(dout), 32'(i));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // ---------------- FWFT instance
        fstep(1'b1, 1'b0, 1'b0, 8'h00);
        chk("fwft.flush_empty", 32'(f_empty), 32'd1);
        chk("fwft.flush_count", 32'(f_count), 32'd0);
        fstep(1'b0, 1'b1, 1'b0, 8'h33);
        chk("fwft.first_dout", 32'(f_dout), 32'h33);
        chk("fwft.first_empty", 32'(f_empty), 32'd0);
        fstep(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fwft.hold_dout", 32'(f_dout), 32'h33);
        fstep(1'b0, 1'b1, 1'b0, 8'h44);
        chk("fwft.second_dout", 32'(f_dout), 32'h33);
        chk("fwft.second_count", 32'(f_count), 32'd2);
        fstep(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fwft.pop1_dout", 32'(f_dout), 32'h44);
        chk("fwft.pop1_count", 32'(f_count), 32'd1);
        fstep(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fwft.pop2_empty", 32'(f_empty), 32'd1);
        chk("fwft.pop2_underflow", 32'(f_underflow), 32'd0);
        fstep(1'b0, 1'b1, 1'b1, 8'h55);
        chk("fwft.both_underflow", 32'(f_underflow), 32'd1);
        chk("fwft.both_count", 32'(f_count), 32'd1);
        chk("fwft.both_empty", 32'(f_empty), 32'd0);
        chk("fwft.both_dout", 32'(f_dout), 32'h55);
        chk("fwft.both_overflow", 32'(f_overflow), 32'd0);
        fstep(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fwft.underflow_clear", 32'(f_underflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
